// File: rtl/alu_acc_datapath.sv
// ---------------------------------------------------------------------------
// alu_acc_datapath
//   Accumulator datapath. It holds an 8-bit combinational ALU, an accumulator
//   register (Acc) and a carry register (CY). ALU operand A is always Acc, and
//   operand R comes from the register file or bus. The ALU result and carry-out
//   are written back to Acc and CY under separate clock enables.
//
//   Optional feature macro: CI_FROM_CY_EN
//     defined   : ALU carry-in is taken from the CY register (ADC/SBC chains).
//                 The Ci port is still present but is ignored.
//     undefined : ALU carry-in is the Ci port, and CY is observe-only.
//
// Ports
//   clk      in   1      rising-edge clock
//   Reset    in   1      async active-high reset; clears Acc and CY
//   ALUCode  in   3      0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT, 6 LD, 7 NOP
//   R        in   WIDTH  second operand
//   Ci       in   1      external carry/borrow in
//   A_CE     in   1      accumulator load enable
//   CY_CE    in   1      carry register load enable
//   ALU_out  out  WIDTH  combinational ALU result
//   Co       out  1      combinational carry/borrow out
//   Acc      out  WIDTH  accumulator register
//   CY       out  1      carry register
// ---------------------------------------------------------------------------
module alu_acc_datapath #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic [2:0]       ALUCode,
    input  logic [WIDTH-1:0] R,
    input  logic             Ci,
    input  logic             A_CE,
    input  logic             CY_CE,
    output logic [WIDTH-1:0] ALU_out,
    output logic             Co,
    output logic [WIDTH-1:0] Acc,
    output logic             CY
);

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_NOT = 3'd5,
        OP_LD  = 3'd6,
        OP_NOP = 3'd7
    } alu_op_e;

    logic             cin;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [WIDTH:0]   cin_ext;

`ifdef CI_FROM_CY_EN
    // Chained arithmetic: the carry from the previous byte feeds this one.
    logic unused_ci;
    assign unused_ci = Ci;
    assign cin = CY;
`else
    assign cin = Ci;
`endif

    assign cin_ext = {{WIDTH{1'b0}}, cin};

    // One extra bit catches the carry. For SUB, the extra bit is set
    // exactly when A < R + cin, which is the borrow.
    assign sum  = {1'b0, Acc} + {1'b0, R} + cin_ext;
    assign diff = {1'b0, Acc} - {1'b0, R} - cin_ext;

    always_comb begin
        ALU_out = Acc;
        Co      = 1'b0;
        case (alu_op_e'(ALUCode))
            OP_ADD: {Co, ALU_out} = sum;
            OP_SUB: {Co, ALU_out} = diff;
            OP_AND: ALU_out = Acc & R;
            OP_OR:  ALU_out = Acc | R;
            OP_XOR: ALU_out = Acc ^ R;
            OP_NOT: ALU_out = ~Acc;
            OP_LD:  ALU_out = R;
            OP_NOP: ALU_out = Acc;  // reloading Acc with itself leaves it unchanged
            default: ALU_out = Acc;
        endcase
    end

    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            Acc <= '0;
            CY  <= 1'b0;
        end else begin
            if (A_CE)  Acc <= ALU_out;
            if (CY_CE) CY  <= Co;
        end
    end

endmodule

// File: tb/tb_alu_acc_datapath.sv
module tb_alu_acc_datapath;

    logic       clk = 1'b0;
    logic       Reset;
    logic [2:0] ALUCode;
    logic [7:0] R;
    logic       Ci;
    logic       A_CE;
    logic       CY_CE;
    logic [7:0] ALU_out;
    logic       Co;
    logic [7:0] Acc;
    logic       CY;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference state: this is the bench's own idea of what Acc and CY hold.
    int m_acc;
    int m_cy;

    alu_acc_datapath #(.WIDTH(8)) dut (
        .clk(clk), .Reset(Reset), .ALUCode(ALUCode), .R(R), .Ci(Ci),
        .A_CE(A_CE), .CY_CE(CY_CE), .ALU_out(ALU_out), .Co(Co),
        .Acc(Acc), .CY(CY)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Behavioural ALU: plain integer arithmetic on 0..255 values.
    task automatic ref_alu(input int op, input int a, input int r, input int cin,
                           output int out, output int co);
        int t;
        co = 0;
        case (op)
            0: begin t = a + r + cin; out = t % 256; co = (t > 255) ? 1 : 0; end
            1: begin t = a - r - cin; out = (t + 512) % 256; co = (t < 0) ? 1 : 0; end
            2: out = a & r;
            3: out = a | r;
            4: out = a ^ r;
            5: out = 255 - a;
            6: out = r;
            default: out = a;
        endcase
    endtask

    // Call this at posedge+1. It checks the comb outputs, then the registers
    // after the next edge.
    task automatic step(input string tag, input int op, input int r, input int ci,
                        input int ace, input int cyce);
        int cin, eo, ec;
        ALUCode = op[2:0]; R = r[7:0]; Ci = ci[0]; A_CE = ace[0]; CY_CE = cyce[0];
`ifdef CI_FROM_CY_EN
        cin = m_cy;
`else
        cin = ci;
`endif
        ref_alu(op, m_acc, r, cin, eo, ec);
        #1;
        chk({tag, ".out"}, {24'd0, ALU_out}, eo);
        chk({tag, ".co"},  {31'd0, Co}, ec);
        @(posedge clk); #1;
        if (ace != 0)  m_acc = eo;
        if (cyce != 0) m_cy  = ec;
        chk({tag, ".acc"}, {24'd0, Acc}, m_acc);
        chk({tag, ".cy"},  {31'd0, CY}, m_cy);
    endtask

    initial begin
        Reset = 1'b1; ALUCode = 3'd0; R = 8'd0; Ci = 1'b0; A_CE = 1'b0; CY_CE = 1'b0;
        m_acc = 0; m_cy = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst.acc", {24'd0, Acc}, 0);
        chk("rst.cy",  {31'd0, CY}, 0);
        chk("rst.out", {24'd0, ALU_out}, 0);
        Reset = 1'b0;

        // Count up by 4, then step back once.
        step("add4a", 0, 4, 0, 1, 1);
        step("add4b", 0, 4, 0, 1, 1);
        step("add4c", 0, 4, 0, 1, 1);
        chk("add4.val", {24'd0, Acc}, 12);
        step("sub4", 1, 4, 0, 1, 1);
        chk("sub4.val", {24'd0, Acc}, 8);

        // Wrap on ADD, then borrow on SUB.
        step("ld_fe", 6, 8'hFE, 0, 1, 1);
        step("add_wrap", 0, 4, 0, 1, 1);
        chk("add_wrap.val", {24'd0, Acc, 7'd0, CY}, {24'h02, 8'h01});
        step("ld_00", 6, 0, 0, 1, 1);
        step("sub_borrow", 1, 4, 0, 1, 1);
        chk("sub_borrow.val", {24'd0, Acc, 7'd0, CY}, {24'hFC, 8'h01});

        // Logic ops with Acc=0x0C, R=0x04.
        step("ld_0c", 6, 8'h0C, 0, 1, 1);
        step("and", 2, 8'h04, 0, 0, 1);
        step("or",  3, 8'h04, 0, 0, 1);
        step("xor", 4, 8'h04, 0, 0, 1);
        step("not", 5, 8'h04, 0, 0, 1);
        step("ld",  6, 8'h04, 0, 1, 1);
        chk("ld.val", {24'd0, Acc}, 8'h04);
        step("nop", 7, 8'h55, 1, 1, 1);

        // Independent enables.
        step("ld_ff", 6, 8'hFF, 0, 1, 1);
        step("cy_only", 0, 1, 0, 0, 1);
        chk("cy_only.val", {24'd0, Acc, 7'd0, CY}, {24'hFF, 8'h01});
        step("acc_only", 2, 8'h0F, 0, 1, 0);
        chk("acc_only.cy", {31'd0, CY}, 1);

        // Carry-in source. CY=1, Acc=0x10, R=0x01, Ci=0.
        step("ld_10", 6, 8'h10, 0, 1, 0);
        step("cin_src", 0, 1, 0, 1, 1);
`ifdef CI_FROM_CY_EN
        chk("cin_src.val", {24'd0, Acc}, 8'h12);
`else
        chk("cin_src.val", {24'd0, Acc}, 8'h11);
`endif

        // Reset asserted mid-cycle with a load pending.
        step("ld_a5", 6, 8'hA5, 0, 1, 0);
        ALUCode = 3'd0; R = 8'd5; A_CE = 1'b1; CY_CE = 1'b1;
        #2 Reset = 1'b1;
        #1;
        chk("midrst.acc", {24'd0, Acc}, 0);
        chk("midrst.cy",  {31'd0, CY}, 0);
        @(posedge clk); #1;
        chk("midrst_hold.acc", {24'd0, Acc}, 0);
        chk("midrst_hold.cy",  {31'd0, CY}, 0);
        Reset = 1'b0;
        m_acc = 0; m_cy = 0;

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step("rand", int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
